// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM generator with shared period counter
//
// All channels share one prescaler and one period counter. Each channel has a
// duty shadow register that is copied into the active duty register only at
// a period wrap (or continuously while disabled), so an update never takes
// effect in the middle of a period.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   enable       1 = run, 0 = hold counters at zero, outputs idle
//   period       period-1 in ticks, taken into use at wrap
//   prescale     one tick every prescale+1 clocks
//   wr_en        duty shadow write strobe
//   wr_addr      channel select; addresses >= CHANNELS are ignored
//   wr_data      duty value, in ticks active
//   out          registered PWM outputs, INVERT bit set = active-low
//   cycle_start  one-clock pulse following each period wrap
module pwm_multi #(
    parameter int                     WIDTH         = 16,
    parameter int                     CHANNELS      = 4,
    parameter int                     ADDR_BITS     = 2,
    parameter int                     PRESCALE_BITS = 8,
    parameter logic [CHANNELS-1:0]    INVERT        = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [WIDTH-1:0]          period,
    input  logic [PRESCALE_BITS-1:0]  prescale,
    input  logic                      wr_en,
    input  logic [ADDR_BITS-1:0]      wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    output logic [CHANNELS-1:0]       out,
    output logic                      cycle_start
);

    logic [PRESCALE_BITS-1:0] pre_cnt;
    logic [WIDTH-1:0]         cnt;
    logic [WIDTH-1:0]         period_act;
    logic [WIDTH-1:0]         shadow   [CHANNELS];
    logic [WIDTH-1:0]         duty_act [CHANNELS];
    logic                     tick;
    logic                     wrap;

    assign tick = enable && (pre_cnt == prescale);
    assign wrap = tick && (cnt == period_act);

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_cnt     <= '0;
            cnt         <= '0;
            period_act  <= '1;
            cycle_start <= 1'b0;
            out         <= INVERT;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i]   <= '0;
                duty_act[i] <= '0;
            end
        end else begin
            // Prescaler: idle at zero while disabled so a re-enable starts
            // a full prescale interval.
            if (!enable || tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end

            if (!enable || wrap) begin
                cnt <= '0;
            end else if (tick) begin
                cnt <= cnt + 1'b1;
            end

            // While disabled the active values track the inputs every clock,
            // so enabling starts a fresh period with current settings.
            if (!enable || wrap) begin
                period_act <= period;
                for (int i = 0; i < CHANNELS; i++) begin
                    duty_act[i] <= shadow[i];
                end
            end

            cycle_start <= wrap;

            // A write on the wrap clock lands in the shadow after duty_act
            // has already sampled the old value, so it applies one period later.
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en && (wr_addr == ADDR_BITS'(i))) begin
                    shadow[i] <= wr_data;
                end
            end

            // Zero-extended compare: duty 0 is never active, duty above the
            // period is always active.
            for (int i = 0; i < CHANNELS; i++) begin
                out[i] <= enable ? (({1'b0, cnt} < {1'b0, duty_act[i]}) ^ INVERT[i])
                                 : INVERT[i];
            end
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// tb/tb_pwm_multi.sv - self-checking bench for pwm_multi
module tb_pwm_multi;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] period;
    logic [7:0]  prescale;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  out_a;
    logic [2:0]  out_b;
    logic        cs_a;
    logic        cs_b;

    always #5 clk = ~clk;

    pwm_multi #(.WIDTH(16), .CHANNELS(4), .ADDR_BITS(2), .PRESCALE_BITS(8),
                .INVERT(4'b0000)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .period(period),
        .prescale(prescale), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .out(out_a), .cycle_start(cs_a));

    pwm_multi #(.WIDTH(16), .CHANNELS(3), .ADDR_BITS(2), .PRESCALE_BITS(8),
                .INVERT(3'b001)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .period(period),
        .prescale(prescale), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .out(out_b), .cycle_start(cs_b));

    typedef struct {
        int                ps;
        int                per;
        logic [3:0][31:0]  d;
        int                sp;
        logic [3:0][31:0]  ha;
        logic [2:0][31:0]  hb;
    } vec_t;

    vec_t vecs [4];
    int   checks = 0;
    int   errors = 0;
    int   ha [4];
    int   hb [3];
    int   ncs;
    int   last_cs;
    bit   ok;
    int   n;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 4; i++) ha[i] = 0;
        for (int i = 0; i < 3; i++) hb[i] = 0;
        ncs = 0;
        last_cs = 0;
    endtask

    task automatic run(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            step();
            for (int i = 0; i < 4; i++) ha[i] += int'(out_a[i]);
            for (int i = 0; i < 3; i++) hb[i] += int'(out_b[i]);
            ncs += int'(cs_a);
            last_cs = int'(cs_a);
        end
    endtask

    task automatic write(input int addr, input int data);
        wr_en   = 1'b1;
        wr_addr = 2'(addr);
        wr_data = 16'(data);
        step();
        wr_en   = 1'b0;
    endtask

    task automatic setup(input int ps, input int per);
        reset = 1'b1;
        enable = 1'b0;
        wr_en = 1'b0;
        step();
        reset = 1'b0;
        prescale = 8'(ps);
        period = 16'(per);
        step();
    endtask

    task automatic wait_cs(output bit found);
        found = 1'b0;
        for (int k = 0; k < 2000 && !found; k++) begin
            step();
            if (cs_a) found = 1'b1;
        end
    endtask

    function automatic vec_t mk(input int ps, input int per,
                                input int d0, input int d1, input int d2, input int d3,
                                input int sp,
                                input int a0, input int a1, input int a2, input int a3,
                                input int b0, input int b1, input int b2);
        vec_t v;
        v.ps = ps; v.per = per; v.sp = sp;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.ha[0] = a0; v.ha[1] = a1; v.ha[2] = a2; v.ha[3] = a3;
        v.hb[0] = b0; v.hb[1] = b1; v.hb[2] = b2;
        return v;
    endfunction

    initial begin
        // ps, per, duty0..3, spacing, high counts a0..a3, high counts b0..b2
        vecs[0] = mk(0, 9, 3, 0, 10, 7,      10, 3, 0, 10, 7,  7, 0, 10);
        vecs[1] = mk(3, 4, 2, 0, 5, 1,       20, 8, 0, 20, 4,  12, 0, 20);
        vecs[2] = mk(1, 2, 1, 3, 2, 16'hFFFF, 6, 2, 6, 4, 6,   4, 6, 4);
        vecs[3] = mk(0, 0, 1, 0, 1, 2,       1, 1, 0, 1, 1,    0, 0, 1);

        reset = 1'b1; enable = 1'b0; period = 16'd9; prescale = 8'd0;
        wr_en = 1'b0; wr_addr = 2'd0; wr_data = 16'd0;
        step(); step();
        reset = 1'b0;
        check("reset_out_a", int'(out_a), 0);
        check("reset_out_b", int'(out_b), 1);
        check("reset_cs", int'(cs_a), 0);

        // Table-driven steady-state period and high-time checks.
        for (int v = 0; v < 4; v++) begin
            setup(vecs[v].ps, vecs[v].per);
            for (int c = 0; c < 4; c++) write(c, int'(vecs[v].d[c]));
            step();
            enable = 1'b1;
            wait_cs(ok);
            check($sformatf("v%0d_first_cs", v), int'(ok), 1);
            clear_counts();
            n = 0;
            do begin
                run(1);
                n++;
            end while (!last_cs && n < 2000);
            check($sformatf("v%0d_spacing", v), n, vecs[v].sp);
            for (int c = 0; c < 4; c++)
                check($sformatf("v%0d_high_a%0d", v, c), ha[c], int'(vecs[v].ha[c]));
            for (int c = 0; c < 3; c++)
                check($sformatf("v%0d_high_b%0d", v, c), hb[c], int'(vecs[v].hb[c]));
        end

        // Shadow timing: mid-period write, then write on the wrap clock.
        setup(0, 9);
        write(0, 3);
        enable = 1'b1;
        wait_cs(ok);
        check("seq4_sync", int'(ok), 1);
        clear_counts();
        run(2);
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 16'd7;
        run(1);
        wr_en = 1'b0;
        run(6);
        wr_en = 1'b1; wr_data = 16'd5;
        run(1);
        wr_en = 1'b0;
        check("seq4_wrap_cs", last_cs, 1);
        check("seq4_ncs", ncs, 1);
        check("seq4_high_cur", ha[0], 3);
        clear_counts();
        run(10);
        check("seq4_high_next", ha[0], 7);
        clear_counts();
        run(10);
        check("seq4_high_after", ha[0], 5);

        // Disable idles outputs; enable restarts immediately with shadow duty.
        setup(0, 9);
        write(0, 4);
        step(); step();
        check("seq5_idle_a", int'(out_a), 0);
        check("seq5_idle_b", int'(out_b), 1);
        enable = 1'b1;
        clear_counts();
        run(1);
        check("seq5_first_a0", int'(out_a[0]), 1);
        check("seq5_first_b0", int'(out_b[0]), 0);
        run(8);
        check("seq5_no_early_cs", ncs, 0);
        run(1);
        check("seq5_cs_at_10", last_cs, 1);
        check("seq5_high", ha[0], 4);

        // Reset mid-period, then ignored write address on the 3-channel unit.
        setup(0, 9);
        write(0, 5);
        enable = 1'b1;
        run(4);
        reset = 1'b1;
        step();
        check("seq6_reset_a", int'(out_a), 0);
        check("seq6_reset_b", int'(out_b), 1);
        check("seq6_reset_cs", int'(cs_a), 0);
        reset = 1'b0;
        enable = 1'b0;
        period = 16'd9;
        prescale = 8'd0;
        step();
        write(3, 5);
        step(); step();
        enable = 1'b1;
        clear_counts();
        run(10);
        check("seq6_shadow_cleared_a0", ha[0], 0);
        check("seq6_addr3_a3", ha[3], 5);
        check("seq6_b0_idle", hb[0], 10);
        check("seq6_b1_untouched", hb[1], 0);
        check("seq6_b2_untouched", hb[2], 0);
        check("seq6_cs", last_cs, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
